button_debouncer: RTL and testbench

Conditions one raw, asynchronous push-button or switch input from a board pin for use by on-chip logic.
- Synchronizes the input, rejects bounce and glitches with a stable-count filter, and emits a clean level plus one-cycle press/release pulses.
- It is the input-side counterpart of the LED output drivers and is used to trigger OCR inference and step debug modes on the FPGA board.

---
 rtl/button_pkg.sv | 18 +
 rtl/btn_sync.sv | 32 +++
 rtl/button_debouncer.sv | 162 ++++++++++++++++
 tb/tb_button_debouncer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and default configuration for the push-button debouncer.
// Contents:
//   btn_state_e         - debounce FSM states
//   DEF_SYNC_STAGES     - default synchronizer depth
//   DEF_DEBOUNCE_CYCLES - default stable-sample count (10 ms at 100 MHz)
package button_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmPress,
    StPressed,
    StArmRelease
  } btn_state_e;

  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/btn_sync.sv
// Single-bit multi-flop synchronizer for asynchronous board inputs (buttons, switches).
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears every stage to 0
//   d_i   - asynchronous input
//   q_o   - synchronized output, SYNC_STAGES clk edges behind d_i
module btn_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronizes a raw pin, filters bounce with a stable-count
// FSM and produces a clean level plus one-cycle press/release pulses.
// Optional long-press detector compiled in with `define BUTTON_DEBOUNCER_LONG_PRESS_EN.
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   btn_raw     - raw pin, asynchronous to clk
//   btn_level   - debounced pressed level
//   btn_press   - one-cycle pulse on accepted press
//   btn_release - one-cycle pulse on accepted release
//   btn_long    - one-cycle long-press pulse (0 when the feature is not built)
module button_debouncer
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES       = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter bit          BTN_ACTIVE_LOW    = 1'b0,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic       btn_sync_out;
  logic       btn_s;
  btn_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       release_q, release_d;

  btn_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (btn_raw),
    .q_o  (btn_sync_out)
  );

  // Inversion sits after the synchronizer so pressed is always 1 internally.
  assign btn_s = btn_sync_out ^ BTN_ACTIVE_LOW;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (btn_s) begin
          state_d = StArmPress;
          cnt_d   = '0;
        end
      end
      StArmPress: begin
        if (!btn_s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StPressed;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPressed: begin
        if (!btn_s) begin
          state_d = StArmRelease;
          cnt_d   = '0;
        end
      end
      StArmRelease: begin
        if (btn_s) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d   = StIdle;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    // Level follows the next state so it moves on the same edge as the pulse.
    level_d = (state_d == StPressed) || (state_d == StArmRelease);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam int unsigned HoldW = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_PRESS_CYCLES - 1);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             long_q, long_d;

  // Hold counter counts one past HoldLast and then sticks, so the pulse fires once per press.
  // A bounce back from ArmRelease keeps the accumulated hold time.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (state_q == StArmPress && state_d == StPressed) begin
      hold_d = '0;
    end else if (state_q == StPressed || state_q == StArmRelease) begin
      long_d = (hold_q == HoldLast);
      if (hold_q <= HoldLast) begin
        hold_d = hold_q + HoldW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign btn_long = long_q;
`else
  logic unused_long_cfg;
  assign unused_long_cfg = ^LONG_PRESS_CYCLES;
  assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: one active-high and one active-low instance, expected pulses
// queued with their cycle stamp when stimulus is driven, popped when a pulse appears.
module tb_button_debouncer;

  localparam int KPress   = 1;
  localparam int KRelease = 2;
  localparam int KLong    = 3;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam bit LongEn = 1'b1;
`else
  localparam bit LongEn = 1'b0;
`endif

  typedef struct {
    int cyc;
    int kind;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic raw_a, raw_b;
  logic level_a, press_a, release_a, long_a;
  logic level_b, press_b, release_b, long_b;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_a[$];
  exp_t exp_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_debouncer #(
    .SYNC_STAGES      (2),
    .DEBOUNCE_CYCLES  (4),
    .BTN_ACTIVE_LOW   (1'b0),
    .LONG_PRESS_CYCLES(10)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (raw_a),
    .btn_level  (level_a),
    .btn_press  (press_a),
    .btn_release(release_a),
    .btn_long   (long_a)
  );

  button_debouncer #(
    .SYNC_STAGES      (2),
    .DEBOUNCE_CYCLES  (4),
    .BTN_ACTIVE_LOW   (1'b1),
    .LONG_PRESS_CYCLES(10)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (raw_b),
    .btn_level  (level_b),
    .btn_press  (press_b),
    .btn_release(release_b),
    .btn_long   (long_b)
  );

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic score(input string tag, input int kind, input logic lvl, input bit is_a);
    exp_t e;
    int   n;
    n = is_a ? exp_a.size() : exp_b.size();
    if (n == 0) begin
      check({tag, "_unexpected"}, kind, 0);
      return;
    end
    if (is_a) e = exp_a.pop_front();
    else      e = exp_b.pop_front();
    check({tag, "_kind"}, kind, e.kind);
    check({tag, "_cycle"}, cyc, e.cyc);
    if (kind == KPress)   check({tag, "_level_hi"}, int'(lvl), 1);
    if (kind == KRelease) check({tag, "_level_lo"}, int'(lvl), 0);
  endtask

  always @(negedge clk) begin
    if (press_a)   score("a_press", KPress, level_a, 1'b1);
    if (release_a) score("a_release", KRelease, level_a, 1'b1);
    if (long_a)    score("a_long", KLong, level_a, 1'b1);
    if (press_a || release_a) check("a_excl", int'(press_a & release_a), 0);
    if (press_b)   score("b_press", KPress, level_b, 1'b0);
    if (release_b) score("b_release", KRelease, level_b, 1'b0);
    if (long_b)    score("b_long", KLong, level_b, 1'b0);
    if (press_b || release_b) check("b_excl", int'(press_b & release_b), 0);
  end

  task automatic push_press_a(input int at);
    exp_a.push_back('{at, KPress});
    if (LongEn) exp_a.push_back('{at + 10, KLong});
  endtask

  initial begin
    rst_n = 1'b0;
    raw_a = 1'b0;
    raw_b = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_level_a", int'(level_a), 0);
    check("rst_press_a", int'(press_a), 0);
    check("rst_release_a", int'(release_a), 0);
    check("rst_long_a", int'(long_a), 0);
    check("rst_level_b", int'(level_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_level_a", int'(level_a), 0);
    check("idle_level_b", int'(level_b), 0);

    // Clean press: first sampling edge is cyc+1, pulse 6 edges later.
    raw_a = 1'b1;
    push_press_a(cyc + 7);
    repeat (40) @(negedge clk);
    check("t1_level", int'(level_a), 1);

    // Clean release.
    raw_a = 1'b0;
    exp_a.push_back('{cyc + 7, KRelease});
    repeat (12) @(negedge clk);
    check("t3_level", int'(level_a), 0);

    // Three-cycle glitch must be rejected.
    raw_a = 1'b1;
    repeat (3) @(negedge clk);
    raw_a = 1'b0;
    repeat (12) @(negedge clk);
    check("t2_glitch_level", int'(level_a), 0);

    // Bounce 1,0,1,0 then steady 1.
    raw_a = 1'b1;
    @(negedge clk) raw_a = 1'b0;
    @(negedge clk) raw_a = 1'b1;
    @(negedge clk) raw_a = 1'b0;
    @(negedge clk) raw_a = 1'b1;
    push_press_a(cyc + 7);
    repeat (40) @(negedge clk);
    check("t2_bounce_level", int'(level_a), 1);
    raw_a = 1'b0;
    exp_a.push_back('{cyc + 7, KRelease});
    repeat (12) @(negedge clk);
    check("t2_bounce_rel_level", int'(level_a), 0);

    // Reset mid-debounce, button kept high through reset.
    raw_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_rst_level", int'(level_a), 0);
    check("t4_rst_press", int'(press_a), 0);
    check("t4_rst_release", int'(release_a), 0);
    check("t4_rst_long", int'(long_a), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_press_a(cyc + 7);
    repeat (40) @(negedge clk);
    check("t4_level", int'(level_a), 1);
    raw_a = 1'b0;
    exp_a.push_back('{cyc + 7, KRelease});
    repeat (12) @(negedge clk);
    check("t4_rel_level", int'(level_a), 0);

    // Active-low instance: press is raw going to 0.
    raw_b = 1'b0;
    exp_b.push_back('{cyc + 7, KPress});
    if (LongEn) exp_b.push_back('{cyc + 17, KLong});
    repeat (30) @(negedge clk);
    check("t5_level", int'(level_b), 1);
    raw_b = 1'b1;
    exp_b.push_back('{cyc + 7, KRelease});
    repeat (12) @(negedge clk);
    check("t5_rel_level", int'(level_b), 0);

    check("a_pending", exp_a.size(), 0);
    check("b_pending", exp_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
